// File: rtl/fighter_action_fsm_if.sv
// Stick/button levels from the controller block plus the fighter's action outputs
// consumed by the sprite renderer and hit-resolution logic.
interface fighter_action_fsm_if;
    logic       frame_tick;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       attack;
    logic       pery;
    logic [3:0] action_state;
    logic       facing;
    logic       hitbox_active;
    logic       parry_active;
    logic       airborne;
    logic       action_done;

    modport master (
        output frame_tick, left, right, up, down, attack, pery,
        input  action_state, facing, hitbox_active, parry_active, airborne, action_done
    );

    modport slave (
        input  frame_tick, left, right, up, down, attack, pery,
        output action_state, facing, hitbox_active, parry_active, airborne, action_done
    );
endinterface

// File: rtl/fighter_action_fsm.sv
// Turns debounced stick/button levels into frame-timed fighter actions
// (walk, crouch, jump, three-phase attack, parry with cooldown).
module fighter_action_fsm #(
    parameter int JUMP_FRAMES    = 24,
    parameter int ATK_STARTUP    = 3,
    parameter int ATK_ACTIVE     = 4,
    parameter int ATK_RECOVER    = 8,
    parameter int PARRY_WINDOW   = 6,
    parameter int PARRY_COOLDOWN = 20,
    parameter int CNT_W          = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fighter_action_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_WALK_L      = 4'd1,
        S_WALK_R      = 4'd2,
        S_CROUCH      = 4'd3,
        S_JUMP        = 4'd4,
        S_ATK_STARTUP = 4'd5,
        S_ATK_ACTIVE  = 4'd6,
        S_ATK_RECOVER = 4'd7,
        S_PARRY       = 4'd8
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    state_t state, state_nxt;
    cnt_t   phase_cnt, phase_nxt;
    cnt_t   cooldown, cooldown_nxt;
    logic   attack_prev, pery_prev;
    logic   atk_buf, atk_buf_nxt;
    logic   facing, facing_nxt;
    logic   done_nxt;
    logic   hitbox_active, parry_active, airborne, action_done;
    logic   atk_edge, par_edge;

    assign atk_edge = bus.attack & ~attack_prev;
    assign par_edge = bus.pery & ~pery_prev;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_cnt;
        atk_buf_nxt  = atk_buf;
        facing_nxt   = facing;
        done_nxt     = 1'b0;
        cooldown_nxt = (cooldown != '0) ? cooldown - 1'b1 : '0;

        unique case (state)
            S_IDLE, S_WALK_L, S_WALK_R, S_CROUCH: begin
                if (par_edge && cooldown == '0) begin
                    state_nxt = S_PARRY;
                    phase_nxt = cnt_t'(PARRY_WINDOW - 1);
                end else if (atk_edge || atk_buf) begin
                    state_nxt   = S_ATK_STARTUP;
                    phase_nxt   = cnt_t'(ATK_STARTUP - 1);
                    atk_buf_nxt = 1'b0;
                end else if (bus.up) begin
                    state_nxt = S_JUMP;
                    phase_nxt = cnt_t'(JUMP_FRAMES - 1);
                end else if (bus.down) begin
                    state_nxt = S_CROUCH;
                end else if (bus.left && !bus.right) begin
                    state_nxt  = S_WALK_L;
                    facing_nxt = 1'b0;
                end else if (bus.right && !bus.left) begin
                    state_nxt  = S_WALK_R;
                    facing_nxt = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_JUMP: begin
                if (phase_cnt == '0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            S_ATK_STARTUP: begin
                if (phase_cnt == '0) begin
                    state_nxt = S_ATK_ACTIVE;
                    phase_nxt = cnt_t'(ATK_ACTIVE - 1);
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            S_ATK_ACTIVE: begin
                if (phase_cnt == '0) begin
                    state_nxt = S_ATK_RECOVER;
                    phase_nxt = cnt_t'(ATK_RECOVER - 1);
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            S_ATK_RECOVER: begin
                // Only recovery may queue the next attack; earlier phases drop the press.
                if (atk_edge) atk_buf_nxt = 1'b1;
                if (phase_cnt == '0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            S_PARRY: begin
                if (phase_cnt == '0) begin
                    state_nxt    = S_IDLE;
                    done_nxt     = 1'b1;
                    cooldown_nxt = cnt_t'(PARRY_COOLDOWN);
                end else begin
                    phase_nxt = phase_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            phase_cnt     <= '0;
            cooldown      <= '0;
            attack_prev   <= 1'b0;
            pery_prev     <= 1'b0;
            atk_buf       <= 1'b0;
            facing        <= 1'b1;
            hitbox_active <= 1'b0;
            parry_active  <= 1'b0;
            airborne      <= 1'b0;
            action_done   <= 1'b0;
        end else begin
            // Done is a single-clk pulse even when ticks are sparse.
            action_done <= 1'b0;
            if (bus.frame_tick) begin
                state         <= state_nxt;
                phase_cnt     <= phase_nxt;
                cooldown      <= cooldown_nxt;
                attack_prev   <= bus.attack;
                pery_prev     <= bus.pery;
                atk_buf       <= atk_buf_nxt;
                facing        <= facing_nxt;
                hitbox_active <= (state_nxt == S_ATK_ACTIVE);
                parry_active  <= (state_nxt == S_PARRY);
                airborne      <= (state_nxt == S_JUMP);
                action_done   <= done_nxt;
            end
        end
    end

    assign bus.action_state  = state;
    assign bus.facing        = facing;
    assign bus.hitbox_active = hitbox_active;
    assign bus.parry_active  = parry_active;
    assign bus.airborne      = airborne;
    assign bus.action_done   = action_done;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed and random stimulus for fighter_action_fsm, checked against a
// frame-schedule reference model (queue of upcoming state codes).
module tb_fighter_action_fsm;

    localparam int JUMP_FRAMES    = 24;
    localparam int ATK_STARTUP    = 3;
    localparam int ATK_ACTIVE     = 4;
    localparam int ATK_RECOVER    = 8;
    localparam int PARRY_WINDOW   = 6;
    localparam int PARRY_COOLDOWN = 20;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fighter_action_fsm_if bus ();

    fighter_action_fsm #(
        .JUMP_FRAMES   (JUMP_FRAMES),
        .ATK_STARTUP   (ATK_STARTUP),
        .ATK_ACTIVE    (ATK_ACTIVE),
        .ATK_RECOVER   (ATK_RECOVER),
        .PARRY_WINDOW  (PARRY_WINDOW),
        .PARRY_COOLDOWN(PARRY_COOLDOWN),
        .CNT_W         (6)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: displayed state plus the queue of states still to be shown.
    int m_state;
    int m_sched[$];
    int m_cd;
    bit m_facing, m_buf, m_atk_prev, m_par_prev, m_done;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_sched.delete(); m_cd = 0;
        m_facing = 1'b1; m_buf = 1'b0; m_atk_prev = 1'b0; m_par_prev = 1'b0; m_done = 1'b0;
    endtask

    task automatic start_action(int code, int frames);
        m_sched.delete();
        repeat (frames) m_sched.push_back(code);
        m_state = m_sched.pop_front();
    endtask

    task automatic start_attack();
        m_sched.delete();
        repeat (ATK_STARTUP) m_sched.push_back(5);
        repeat (ATK_ACTIVE)  m_sched.push_back(6);
        repeat (ATK_RECOVER) m_sched.push_back(7);
        m_state = m_sched.pop_front();
    endtask

    task automatic model_tick();
        bit ae, pe;
        int cd_pre;
        ae = bus.attack && !m_atk_prev;
        pe = bus.pery && !m_par_prev;
        cd_pre = m_cd;
        m_atk_prev = bus.attack;
        m_par_prev = bus.pery;
        m_done = 1'b0;
        if (m_cd > 0) m_cd--;
        if (m_state >= 4) begin
            if (m_state == 7 && ae) m_buf = 1'b1;
            if (m_sched.size() > 0) m_state = m_sched.pop_front();
            else begin
                if (m_state == 8) m_cd = PARRY_COOLDOWN;
                m_state = 0;
                m_done  = 1'b1;
            end
        end else if (pe && cd_pre == 0) start_action(8, PARRY_WINDOW);
        else if (ae || m_buf) begin
            m_buf = 1'b0;
            start_attack();
        end
        else if (bus.up)                    start_action(4, JUMP_FRAMES);
        else if (bus.down)                  m_state = 3;
        else if (bus.left && !bus.right) begin m_state = 1; m_facing = 1'b0; end
        else if (bus.right && !bus.left) begin m_state = 2; m_facing = 1'b1; end
        else                                m_state = 0;
    endtask

    task automatic check_outputs();
        check("action_state",  bus.action_state,  m_state);
        check("facing",        bus.facing,        m_facing);
        check("hitbox_active", bus.hitbox_active, m_state == 6);
        check("parry_active",  bus.parry_active,  m_state == 8);
        check("airborne",      bus.airborne,      m_state == 4);
        check("action_done",   bus.action_done,   m_done);
    endtask

    // Called at a negedge; inputs are already set by the caller.
    task automatic cycle(bit tick);
        bus.frame_tick = tick;
        @(posedge clk);
        if (tick) model_tick();
        else m_done = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(int n);
        repeat (n) cycle(1'b1);
    endtask

    task automatic set_in(bit l, bit r, bit u, bit d, bit a, bit p);
        bus.left = l; bus.right = r; bus.up = u; bus.down = d; bus.attack = a; bus.pery = p;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.frame_tick = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Idle after reset, including non-tick cycles.
        ticks(5);
        cycle(1'b0);

        // Attack held high: exactly one attack, then IDLE with done.
        set_in(0, 0, 0, 0, 1, 0);
        ticks(20);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(2);

        // Async reset during ATK_ACTIVE.
        set_in(0, 0, 0, 0, 1, 0);
        ticks(5);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_state",  bus.action_state,  4'd0);
        check("async_rst_hitbox", bus.hitbox_active, 1'b0);
        model_reset();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(3);

        // Jump with an attack pulse mid-air; no attack after landing.
        set_in(0, 0, 1, 0, 0, 0);
        ticks(2);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(5);
        set_in(0, 0, 0, 0, 1, 0);
        ticks(1);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(25);

        // Parry, re-press during cooldown while walking right, re-press after cooldown.
        set_in(0, 0, 0, 0, 0, 1);
        ticks(1);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(15);
        set_in(0, 1, 0, 0, 0, 1);
        ticks(2);
        set_in(0, 1, 0, 0, 0, 0);
        ticks(12);
        set_in(0, 0, 0, 0, 0, 1);
        ticks(1);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(8);

        // Two edges during recovery: only one buffered attack.
        ticks(15);
        set_in(0, 0, 0, 0, 1, 0);
        ticks(1);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(8);
        set_in(0, 0, 0, 0, 1, 0);
        ticks(1);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(1);
        set_in(0, 0, 0, 0, 1, 0);
        ticks(1);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(40);

        // left&right together, walk left first so facing must stay 0.
        set_in(1, 0, 0, 0, 0, 0);
        ticks(2);
        set_in(1, 1, 0, 0, 0, 0);
        ticks(3);
        set_in(0, 0, 1, 1, 0, 0);
        ticks(1);
        set_in(0, 0, 0, 1, 0, 0);
        ticks(26);

        // Simultaneous parry and attack edges from IDLE.
        set_in(0, 0, 0, 0, 1, 1);
        ticks(1);
        set_in(0, 0, 0, 0, 1, 0);
        ticks(10);
        set_in(0, 0, 0, 0, 0, 0);
        ticks(3);

        // Random stimulus with sparse ticks and slowly toggling inputs.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.left   = ~bus.left;
            if ($urandom_range(0, 7) == 0) bus.right  = ~bus.right;
            if ($urandom_range(0, 15) == 0) bus.up    = ~bus.up;
            if ($urandom_range(0, 11) == 0) bus.down  = ~bus.down;
            if ($urandom_range(0, 5) == 0) bus.attack = ~bus.attack;
            if ($urandom_range(0, 7) == 0) bus.pery   = ~bus.pery;
            cycle($urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
